// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared widths, reset PC, fetch FSM encodings and PC helpers
package pc_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;
  localparam addr_t RESET_PC_DEF = '0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  function automatic addr_t pc_plus4(input addr_t pc);
    return pc + addr_t'(4);
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, instruction-memory and decode handshake signals of the fetch unit
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;
  logic   redirect;
  addr_t  redirect_pc;
  logic   stall;
  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_gnt;
  logic   imem_rvalid;
  instr_t imem_rdata;
  logic   if_valid;
  logic   if_ready;
  addr_t  if_pc;
  addr_t  if_pc_plus4;
  instr_t if_instr;
  logic   fetch_fault;
  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault
  );
  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault
  );
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: XLEN-wide 2:1 next-PC select, b chosen when sel is high
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic  i_sel,
  input  addr_t i_a,
  input  addr_t i_b,
  output addr_t o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding fetch sequencer feeding decode
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF
) (
  input logic clk,
  input logic rst,
  pc_fetch_unit_if.master bus
);
  logic [1:0] r_state;
  addr_t      r_pc;
  logic       r_drop;
  logic       r_if_valid;
  logic       r_fault;
  addr_t      r_if_pc;
  addr_t      r_if_pc_plus4;
  instr_t     r_if_instr;
  logic       w_redir;
  logic       w_misal;
  logic       w_accept;
  addr_t      w_pc_plus4;
  addr_t      w_next_pc;
  assign w_redir    = bus.redirect & (bus.redirect_pc[1:0] == 2'b00);
  assign w_misal    = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
  assign w_accept   = (r_state == S_HOLD) & r_if_valid & bus.if_ready & ~bus.stall;
  assign w_pc_plus4 = pc_plus4(r_pc);
  pc_next_mux u_mux (
    .i_sel (w_redir),
    .i_a   (w_pc_plus4),
    .i_b   (bus.redirect_pc),
    .o_y   (w_next_pc)
  );
  // A redirect landing in the same cycle as the response discards it instead of waiting forever
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_if_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_instr    <= '0;
    end else begin
      r_fault <= w_misal;
      if (w_redir | w_accept) begin
        r_pc       <= w_next_pc;
        r_if_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: if (bus.imem_gnt) begin
          r_state <= S_WAIT;
          r_drop  <= w_redir;
        end
        S_WAIT: if (bus.imem_rvalid) begin
          r_drop <= 1'b0;
          if (r_drop | w_redir) r_state <= S_REQ;
          else begin
            r_if_instr    <= bus.imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_valid    <= 1'b1;
            r_state       <= S_HOLD;
          end
        end else if (w_redir) r_drop <= 1'b1;
        default: if (w_redir | w_accept) r_state <= S_REQ;
      endcase
    end
  end
  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc_plus4;
  assign bus.if_instr    = r_if_instr;
  assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench with a latency-programmable instruction memory model
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int total = 0;
  int bad = 0;
  int faults = 0;
  int lat = 1;
  int c = 0;
  logic [31:0] ra = '0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_acc[$];
  logic [31:0] g2q[$];
  logic [31:0] a2_pc[$];
  logic [31:0] a2_p4[$];
  logic [31:0] a2_in[$];
  typedef struct {
    int          low;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[4];
  pc_fetch_unit_if bus();
  pc_fetch_unit_if bus2();
  pc_fetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus));
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic cyc();
    logic g;
    logic g2;
    logic [31:0] e;
    logic [31:0] a2;
    bus.imem_gnt = (exp_addr.size() != 0);
    g = bus.imem_req & bus.imem_gnt;
    if (g) begin
      e = exp_addr.pop_front();
      ra = bus.imem_addr;
      chk("grant_addr", bus.imem_addr, e);
    end
    if (bus.if_valid & bus.if_ready & ~bus.stall) begin
      if (exp_acc.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept actual_pc=%h required=none", bus.if_pc);
      end else begin
        e = exp_acc.pop_front();
        chk("if_pc", bus.if_pc, e);
        chk("if_pc_plus4", bus.if_pc_plus4, e + 32'd4);
        chk("if_instr", bus.if_instr, f(e));
      end
    end
    if (bus.fetch_fault === 1'b1) faults++;
    g2 = bus2.imem_req === 1'b1;
    a2 = bus2.imem_addr;
    if (g2) g2q.push_back(a2);
    if (bus2.if_valid === 1'b1) begin
      a2_pc.push_back(bus2.if_pc);
      a2_p4.push_back(bus2.if_pc_plus4);
      a2_in.push_back(bus2.if_instr);
    end
    @(posedge clk);
    #1;
    if (g) c = lat;
    else if (c > 0) c--;
    bus.imem_rvalid = (c == 1);
    bus.imem_rdata  = (c == 1) ? f(ra) : 32'h0;
    bus2.imem_rvalid = g2;
    bus2.imem_rdata  = f(a2);
  endtask
  task automatic run_until_empty();
    int n = 0;
    while ((exp_addr.size() != 0 || exp_acc.size() != 0) && n < 60) begin
      cyc();
      n++;
    end
    chk("drain_left", exp_addr.size() + exp_acc.size(), 0);
  endtask
  task automatic run_until_valid();
    int n = 0;
    while (bus.if_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("valid_seen", bus.if_valid, 1);
  endtask
  task automatic push(input logic [31:0] a, input logic acc);
    exp_addr.push_back(a);
    if (acc) exp_acc.push_back(a);
  endtask
  initial begin
    int f0;
    tbl[0] = '{0, 32'h0000_000C};
    tbl[1] = '{5, 32'h0000_0010};
    tbl[2] = '{2, 32'h0000_0014};
    tbl[3] = '{1, 32'h0000_0018};
    bus.redirect = 0; bus.redirect_pc = 0; bus.stall = 0; bus.imem_gnt = 0;
    bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.if_ready = 1;
    bus2.redirect = 0; bus2.redirect_pc = 0; bus2.stall = 0; bus2.imem_gnt = 1;
    bus2.imem_rvalid = 0; bus2.imem_rdata = 0; bus2.if_ready = 1;
    rst = 1; rst2 = 1;
    #1;
    repeat (2) cyc();
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_if_pc_plus4", bus.if_pc_plus4, 0);
    chk("rst_if_instr", bus.if_instr, 0);
    chk("rst_fetch_fault", bus.fetch_fault, 0);
    rst = 0;
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
    run_until_empty();
    chk("no_fault_seq", faults, 0);
    foreach (tbl[i]) begin
      bus.if_ready = 0;
      push(tbl[i].pc, 1);
      run_until_valid();
      for (int k = 0; k < tbl[i].low; k++) begin
        chk("hold_valid", bus.if_valid, 1);
        chk("hold_pc", bus.if_pc, tbl[i].pc);
        chk("hold_instr", bus.if_instr, f(tbl[i].pc));
        chk("hold_no_req", bus.imem_req, 0);
        cyc();
      end
      bus.if_ready = 1;
      run_until_empty();
    end
    lat = 3;
    push(32'h1C, 0);
    run_until_empty();
    bus.redirect = 1; bus.redirect_pc = 32'h100;
    push(32'h100, 1);
    cyc();
    bus.redirect = 0;
    run_until_empty();
    lat = 1;
    f0 = faults;
    bus.redirect = 1; bus.redirect_pc = 32'h102;
    cyc();
    bus.redirect = 0;
    repeat (4) cyc();
    chk("fault_cycles", faults - f0, 1);
    chk("misal_req_held", bus.imem_req, 1);
    chk("misal_addr_held", bus.imem_addr, 32'h104);
    push(32'h104, 1);
    run_until_empty();
    bus.stall = 1;
    push(32'h108, 0);
    run_until_valid();
    repeat (3) begin
      chk("stall_valid", bus.if_valid, 1);
      chk("stall_pc", bus.if_pc, 32'h108);
      cyc();
    end
    bus.redirect = 1; bus.redirect_pc = 32'h200;
    cyc();
    bus.redirect = 0;
    chk("stall_redir_valid", bus.if_valid, 0);
    chk("stall_redir_req", bus.imem_req, 1);
    chk("stall_redir_addr", bus.imem_addr, 32'h200);
    bus.stall = 0;
    push(32'h200, 1);
    run_until_empty();
    lat = 3;
    push(32'h204, 0);
    run_until_empty();
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_req", bus.imem_req, 0);
    chk("mid_rst_valid", bus.if_valid, 0);
    chk("mid_rst_pc", bus.if_pc, 0);
    repeat (6) begin
      chk("late_rvalid_ignored", bus.if_valid, 0);
      cyc();
    end
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    lat = 1;
    push(32'h0, 1);
    run_until_empty();
    rst2 = 0;
    repeat (10) cyc();
    chk("wrap_grants", g2q.size() >= 2, 1);
    chk("wrap_accepts", a2_pc.size() >= 1, 1);
    if (g2q.size() >= 2) begin
      chk("wrap_first_addr", g2q[0], 32'hFFFF_FFFC);
      chk("wrap_second_addr", g2q[1], 32'h0);
    end
    if (a2_pc.size() >= 1) begin
      chk("wrap_if_pc", a2_pc[0], 32'hFFFF_FFFC);
      chk("wrap_if_pc_plus4", a2_p4[0], 32'h0);
      chk("wrap_if_instr", a2_in[0], f(32'hFFFF_FFFC));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
